// File: rtl/ps2_frame_receiver_if.sv
// PS/2 pin inputs and decoded keyboard outputs of the frame receiver.
// PS2_ERR_COUNT_EN adds the saturating err_count output.
interface ps2_frame_receiver_if;
  logic       PS2Clk;
  logic       PS2Data;
  logic [7:0] keycode;
  logic       extended;
  logic [7:0] rx_byte;
  logic       key_valid;
  logic       key_release;
  logic       parity_err;
  logic       frame_err;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0] err_count;

  modport master (output PS2Clk, PS2Data,
                  input  keycode, extended, rx_byte, key_valid, key_release,
                         parity_err, frame_err, err_count);
  modport slave  (input  PS2Clk, PS2Data,
                  output keycode, extended, rx_byte, key_valid, key_release,
                         parity_err, frame_err, err_count);
`else
  modport master (output PS2Clk, PS2Data,
                  input  keycode, extended, rx_byte, key_valid, key_release,
                         parity_err, frame_err);
  modport slave  (input  PS2Clk, PS2Data,
                  output keycode, extended, rx_byte, key_valid, key_release,
                         parity_err, frame_err);
`endif
endinterface

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: sync, clock glitch filter, 11-bit deserialiser, F0/E0 tracking.
// Optional macro PS2_ERR_COUNT_EN adds a saturating error counter.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ps2_frame_receiver_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;

  logic [1:0]    ck_s, dt_s;
  logic          fclk, fclk_q, fall, sdat;
  logic [7:0]    fcnt;
  logic [2:0]    bcnt, bcnt_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par, par_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          brk_pend, brk_nx, ext_pend, ext_nx;
  logic [7:0]    key_nx, rx_nx;
  logic          exto_nx, kv_nx, kr_nx, pe_nx, fe_nx;

  assign fall = fclk_q & ~fclk;
  assign sdat = dt_s[1];

  // Filtered clock follows the synchronised clock only after FILTER_LEN differing samples in a row
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ck_s   <= 2'b11;
      dt_s   <= 2'b11;
      fclk   <= 1'b1;
      fclk_q <= 1'b1;
      fcnt   <= '0;
    end else begin
      ck_s   <= {ck_s[0], bus.PS2Clk};
      dt_s   <= {dt_s[0], bus.PS2Data};
      fclk_q <= fclk;
      if (ck_s[1] == fclk) fcnt <= '0;
      else if (fcnt == 8'(FILTER_LEN - 1)) begin
        fclk <= ck_s[1];
        fcnt <= '0;
      end else fcnt <= fcnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      bcnt            <= '0;
      shreg           <= '0;
      par             <= 1'b0;
      tcnt            <= '0;
      brk_pend        <= 1'b0;
      ext_pend        <= 1'b0;
      bus.keycode     <= '0;
      bus.extended    <= 1'b0;
      bus.rx_byte     <= '0;
      bus.key_valid   <= 1'b0;
      bus.key_release <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      state           <= state_nx;
      bcnt            <= bcnt_nx;
      shreg           <= shreg_nx;
      par             <= par_nx;
      tcnt            <= tcnt_nx;
      brk_pend        <= brk_nx;
      ext_pend        <= ext_nx;
      bus.keycode     <= key_nx;
      bus.extended    <= exto_nx;
      bus.rx_byte     <= rx_nx;
      bus.key_valid   <= kv_nx;
      bus.key_release <= kr_nx;
      bus.parity_err  <= pe_nx;
      bus.frame_err   <= fe_nx;
    end
  end

  always_comb begin
    state_nx = state;
    bcnt_nx  = bcnt;
    shreg_nx = shreg;
    par_nx   = par;
    tcnt_nx  = tcnt;
    brk_nx   = brk_pend;
    ext_nx   = ext_pend;
    key_nx   = bus.keycode;
    exto_nx  = bus.extended;
    rx_nx    = bus.rx_byte;
    kv_nx    = 1'b0;
    kr_nx    = 1'b0;
    pe_nx    = 1'b0;
    fe_nx    = 1'b0;
    if (fall) begin
      tcnt_nx = '0;
      case (state)
        IDLE: begin
          if (!sdat) begin
            state_nx = DATA;
            bcnt_nx  = '0;
          end else begin
            fe_nx  = 1'b1;
            brk_nx = 1'b0;
            ext_nx = 1'b0;
          end
        end
        DATA: begin
          shreg_nx = {sdat, shreg[7:1]};
          bcnt_nx  = bcnt + 3'd1;
          if (bcnt == 3'd7) state_nx = PARITY;
        end
        PARITY: begin
          par_nx   = sdat;
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!sdat || (^shreg ^ par) != 1'b1) begin
            fe_nx  = ~sdat;
            pe_nx  = sdat;
            brk_nx = 1'b0;
            ext_nx = 1'b0;
          end else begin
            rx_nx = shreg;
            if (shreg == 8'hF0) brk_nx = 1'b1;
            else if (shreg == 8'hE0) ext_nx = 1'b1;
            else if (brk_pend) begin
              kr_nx = 1'b1;
              if (bus.keycode == shreg) begin
                key_nx  = '0;
                exto_nx = 1'b0;
              end
              brk_nx = 1'b0;
              ext_nx = 1'b0;
            end else begin
              kv_nx   = 1'b1;
              key_nx  = shreg;
              exto_nx = ext_pend;
              ext_nx  = 1'b0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end else if (state != IDLE) begin
      // Device stopped clocking mid-frame: abandon it
      if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state_nx = IDLE;
        tcnt_nx  = '0;
        fe_nx    = 1'b1;
        brk_nx   = 1'b0;
        ext_nx   = 1'b0;
      end else tcnt_nx = tcnt + TW'(1);
    end
  end

`ifdef PS2_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) bus.err_count <= '0;
    else if ((pe_nx | fe_nx) && bus.err_count != 8'hFF) bus.err_count <= bus.err_count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver; short filter/timeout and a fast bit period keep the run small.
module tb_ps2_frame_receiver;
  localparam int FL = 4;
  localparam int TO = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ps2_frame_receiver_if bus();

  ps2_frame_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int n_kv = 0, n_kr = 0, n_pe = 0, n_fe = 0, n_multi = 0;
  int kv_cyc = 0, fe_cyc = 0;
  int s_kv, s_kr, s_pe, s_fe;
  int half = 20;
  int last_fall = 0;
  int lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.key_valid)   begin n_kv <= n_kv + 1; kv_cyc <= cyc; end
    if (bus.key_release) n_kr <= n_kr + 1;
    if (bus.parity_err)  n_pe <= n_pe + 1;
    if (bus.frame_err)   begin n_fe <= n_fe + 1; fe_cyc <= cyc; end
    if (32'(bus.key_valid) + 32'(bus.key_release) + 32'(bus.parity_err) + 32'(bus.frame_err) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    s_kv = n_kv; s_kr = n_kr; s_pe = n_pe; s_fe = n_fe;
  endtask

  // Glitches are FL-1 cycles long, one short of what the filter accepts
  task automatic send_bit(input logic b, input bit glitch);
    bus.PS2Data = b;
    if (glitch) begin
      wait_cyc(half / 4);
      bus.PS2Clk = 1'b0; wait_cyc(FL - 1); bus.PS2Clk = 1'b1;
      wait_cyc(half - half / 4 - (FL - 1));
    end else wait_cyc(half);
    bus.PS2Clk = 1'b0;
    last_fall = cyc;
    if (glitch) begin
      wait_cyc(half / 4);
      bus.PS2Clk = 1'b1; wait_cyc(FL - 1); bus.PS2Clk = 1'b0;
      wait_cyc(half - half / 4 - (FL - 1));
    end else wait_cyc(half);
    bus.PS2Clk = 1'b1;
  endtask

  // nbits < 11 stops after that many bits and leaves the clock high
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                            input bit glitch, input int nbits);
    logic [10:0] f;
    f = {stop, ~(^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(f[i], glitch);
    bus.PS2Data = 1'b1;
    if (nbits == 11) wait_cyc(2 * half);
  endtask

  task automatic test_reset();
    bus.PS2Clk = 1'b1; bus.PS2Data = 1'b1; rst_n = 1'b0;
    wait_cyc(4);
    n_chk++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL reset keycode got=%h exp=00", bus.keycode); end
    n_chk++; if (bus.rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset rx_byte got=%h exp=00", bus.rx_byte); end
    n_chk++; if ({bus.extended, bus.key_valid, bus.key_release, bus.parity_err, bus.frame_err} !== 5'b0)
      begin n_fail++; $display("FAIL reset flags got=%b exp=00000",
        {bus.extended, bus.key_valid, bus.key_release, bus.parity_err, bus.frame_err}); end
`ifdef PS2_ERR_COUNT_EN
    n_chk++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL reset err_count got=%h exp=00", bus.err_count); end
`endif
    rst_n = 1'b1;
    wait_cyc(10);
  endtask

  task automatic test_make();
    snap();
    send_frame(8'h1C, 0, 1, 0, 11);
    lat = kv_cyc - last_fall;
    n_chk++; if (n_kv - s_kv !== 1) begin n_fail++; $display("FAIL make key_valid count got=%0d exp=1", n_kv - s_kv); end
    n_chk++; if (bus.keycode !== 8'h1C) begin n_fail++; $display("FAIL make keycode got=%h exp=1c", bus.keycode); end
    n_chk++; if (bus.extended !== 1'b0) begin n_fail++; $display("FAIL make extended got=%b exp=0", bus.extended); end
    n_chk++; if (bus.rx_byte !== 8'h1C) begin n_fail++; $display("FAIL make rx_byte got=%h exp=1c", bus.rx_byte); end
    n_chk++; if ((n_kr - s_kr) + (n_pe - s_pe) + (n_fe - s_fe) !== 0)
      begin n_fail++; $display("FAIL make stray pulses got=%0d exp=0", (n_kr - s_kr) + (n_pe - s_pe) + (n_fe - s_fe)); end
  endtask

  task automatic test_break();
    snap();
    send_frame(8'hF0, 0, 1, 0, 11);
    n_chk++; if ((n_kv - s_kv) + (n_kr - s_kr) !== 0) begin n_fail++; $display("FAIL break F0 strobes got=%0d exp=0", (n_kv - s_kv) + (n_kr - s_kr)); end
    n_chk++; if (bus.rx_byte !== 8'hF0) begin n_fail++; $display("FAIL break rx_byte got=%h exp=f0", bus.rx_byte); end
    n_chk++; if (bus.keycode !== 8'h1C) begin n_fail++; $display("FAIL break held keycode got=%h exp=1c", bus.keycode); end
    send_frame(8'h1C, 0, 1, 0, 11);
    n_chk++; if (n_kr - s_kr !== 1) begin n_fail++; $display("FAIL break key_release count got=%0d exp=1", n_kr - s_kr); end
    n_chk++; if (bus.keycode !== 8'h00) begin n_fail++; $display("FAIL break keycode got=%h exp=00", bus.keycode); end
    n_chk++; if (bus.rx_byte !== 8'h1C) begin n_fail++; $display("FAIL break rx_byte got=%h exp=1c", bus.rx_byte); end
  endtask

  task automatic test_extended();
    snap();
    send_frame(8'hE0, 0, 1, 0, 11);
    send_frame(8'h75, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1) begin n_fail++; $display("FAIL ext key_valid count got=%0d exp=1", n_kv - s_kv); end
    n_chk++; if (bus.keycode !== 8'h75) begin n_fail++; $display("FAIL ext keycode got=%h exp=75", bus.keycode); end
    n_chk++; if (bus.extended !== 1'b1) begin n_fail++; $display("FAIL ext extended got=%b exp=1", bus.extended); end
    snap();
    send_frame(8'hE0, 0, 1, 0, 11);
    send_frame(8'hF0, 0, 1, 0, 11);
    send_frame(8'h75, 0, 1, 0, 11);
    n_chk++; if (n_kr - s_kr !== 1 || n_kv - s_kv !== 0)
      begin n_fail++; $display("FAIL ext release counts got kr=%0d kv=%0d exp kr=1 kv=0", n_kr - s_kr, n_kv - s_kv); end
    n_chk++; if ({bus.keycode, bus.extended} !== 9'h000)
      begin n_fail++; $display("FAIL ext release key got=%h/%b exp=00/0", bus.keycode, bus.extended); end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 0, 1, 0, 11);
    snap();
    send_frame(8'h15, 1, 1, 0, 11);
    n_chk++; if (n_pe - s_pe !== 1) begin n_fail++; $display("FAIL parity parity_err count got=%0d exp=1", n_pe - s_pe); end
    n_chk++; if (bus.keycode !== 8'h1C || bus.rx_byte !== 8'h1C)
      begin n_fail++; $display("FAIL parity held got key=%h rx=%h exp 1c/1c", bus.keycode, bus.rx_byte); end
    send_frame(8'h1D, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1 || bus.keycode !== 8'h1D)
      begin n_fail++; $display("FAIL parity recover got kv=%0d key=%h exp 1/1d", n_kv - s_kv, bus.keycode); end
    // Typematic repeat, then a break broken by an error must not act as a release
    snap();
    send_frame(8'h1D, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1 || bus.keycode !== 8'h1D)
      begin n_fail++; $display("FAIL typematic got kv=%0d key=%h exp 1/1d", n_kv - s_kv, bus.keycode); end
    snap();
    send_frame(8'hF0, 0, 1, 0, 11);
    send_frame(8'h15, 1, 1, 0, 11);
    send_frame(8'h1D, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1 || n_kr - s_kr !== 0 || bus.keycode !== 8'h1D)
      begin n_fail++; $display("FAIL err clears brk got kv=%0d kr=%0d key=%h exp 1/0/1d", n_kv - s_kv, n_kr - s_kr, bus.keycode); end
  endtask

  task automatic test_glitch();
    snap();
    send_frame(8'h2A, 0, 1, 1, 11);
    n_chk++; if (n_kv - s_kv !== 1 || bus.keycode !== 8'h2A)
      begin n_fail++; $display("FAIL glitch got kv=%0d key=%h exp 1/2a", n_kv - s_kv, bus.keycode); end
    n_chk++; if ((n_pe - s_pe) + (n_fe - s_fe) !== 0)
      begin n_fail++; $display("FAIL glitch errors got=%0d exp=0", (n_pe - s_pe) + (n_fe - s_fe)); end
  endtask

  task automatic test_timeout();
    int tfall;
    send_frame(8'hF0, 0, 1, 0, 11);
    snap();
    send_frame(8'h24, 0, 1, 0, 5);
    tfall = last_fall;
    for (int i = 0; i < TO + 200 && n_fe == s_fe; i++) wait_cyc(1);
    wait_cyc(2);
    n_chk++; if (n_fe - s_fe !== 1) begin n_fail++; $display("FAIL timeout frame_err count got=%0d exp=1", n_fe - s_fe); end
    n_chk++; if (fe_cyc - tfall !== lat + TO)
      begin n_fail++; $display("FAIL timeout delay got=%0d exp=%0d", fe_cyc - tfall - lat, TO); end
    send_frame(8'h24, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1 || n_kr - s_kr !== 0 || bus.keycode !== 8'h24)
      begin n_fail++; $display("FAIL timeout next got kv=%0d kr=%0d key=%h exp 1/0/24", n_kv - s_kv, n_kr - s_kr, bus.keycode); end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h76, 0, 1, 0, 6);
    snap();
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    n_chk++; if ({bus.keycode, bus.rx_byte, bus.extended} !== 17'h0)
      begin n_fail++; $display("FAIL midreset outputs got key=%h rx=%h ext=%b exp 0", bus.keycode, bus.rx_byte, bus.extended); end
`ifdef PS2_ERR_COUNT_EN
    n_chk++; if (bus.err_count !== 8'h00) begin n_fail++; $display("FAIL midreset err_count got=%h exp=00", bus.err_count); end
`endif
    wait_cyc(4 * half);
    n_chk++; if ((n_kv - s_kv) + (n_kr - s_kr) + (n_pe - s_pe) + (n_fe - s_fe) !== 0)
      begin n_fail++; $display("FAIL midreset pulses got=%0d exp=0", (n_kv - s_kv) + (n_kr - s_kr) + (n_pe - s_pe) + (n_fe - s_fe)); end
    send_frame(8'h76, 0, 1, 0, 11);
    n_chk++; if (n_kv - s_kv !== 1 || bus.keycode !== 8'h76)
      begin n_fail++; $display("FAIL midreset next got kv=%0d key=%h exp 1/76", n_kv - s_kv, bus.keycode); end
  endtask

`ifdef PS2_ERR_COUNT_EN
  task automatic test_err_count();
    half = 8;
    snap();
    for (int i = 0; i < 300; i++) send_frame(8'h00, 0, 0, 0, 11);
    half = 20;
    n_chk++; if (n_fe - s_fe !== 300) begin n_fail++; $display("FAIL errcnt frame_err count got=%0d exp=300", n_fe - s_fe); end
    n_chk++; if (bus.err_count !== 8'hFF) begin n_fail++; $display("FAIL errcnt saturation got=%0d exp=255", bus.err_count); end
    n_chk++; if (bus.keycode !== 8'h76) begin n_fail++; $display("FAIL errcnt keycode got=%h exp=76", bus.keycode); end
  endtask
`endif

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity();
    test_glitch();
    test_timeout();
    test_reset_midframe();
`ifdef PS2_ERR_COUNT_EN
    test_err_count();
`endif
    n_chk++; if (n_multi !== 0) begin n_fail++; $display("FAIL exclusive pulses overlap got=%0d exp=0", n_multi); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Front end of the keyboard path. Samples the raw PS/2 clock and data lines, filters and synchronises them, and deserialises 11-bit device-to-host frames. Tracks the F0 (break) and E0 (extended) prefixes and presents a held 8-bit make code plus event strobes. The keyboard code mapper downstream consumes keycode directly; it maps 8'h00 to "no key".

Parameters:
FILTER_LEN, 8, number of consecutive clk cycles a synchronised PS2Clk level must hold before the filtered clock follows it (legal range 2..255)
TIMEOUT_CYCLES, 100000, clk cycles without a filtered PS2Clk falling edge mid-frame before the frame is aborted (1 ms at 100 MHz)

Ports:
clk  input  1  system clock, 100 MHz
rst_n  input  1  synchronous reset, active low
PS2Clk  input  1  raw PS/2 clock from the pin, asynchronous
PS2Data  input  1  raw PS/2 data from the pin, asynchronous
keycode  output  8  make code of the currently held key; 8'h00 when no key is held
extended  output  1  keycode was preceded by E0
rx_byte  output  8  last byte received without error, including prefix bytes F0 and E0
key_valid  output  1  one-cycle pulse; a new make code was loaded into keycode
key_release  output  1  one-cycle pulse; a break sequence (F0 xx) completed; the released code is in rx_byte
parity_err  output  1  one-cycle pulse; odd parity check failed
frame_err  output  1  one-cycle pulse; bad start bit, bad stop bit, or timeout

Behaviour:
- Reset (rst_n low at a clk edge): all outputs are 0, FSM is IDLE, pending flags are cleared, and the filter state is 1 (bus idle-high).
- Sync: both PS2Clk and PS2Data pass through a 2-FF synchroniser.
- Filter: a counter tracks how long the synchronised clock has held a level different from the filtered clock. The filtered clock changes after FILTER_LEN consecutive equal samples. Any reversion before that resets the counter.
- Edge detect: fall = filtered clock was 1 on the previous cycle and is 0 on this cycle. PS2Data (synchronised) is sampled on the fall cycle.
- Frame format: start bit 0, D0..D7 (LSB first), odd parity, stop bit 1.
- FSM states:
  - IDLE, on fall: if data = 0, go to DATA with bit count 0. If data = 1, pulse frame_err and stay in IDLE.
  - DATA, on fall: shift the bit in. After the 8th bit, go to PARITY.
  - PARITY, on fall: store the parity bit and go to STOP.
  - STOP, on fall: always return to IDLE. If stop = 0, pulse frame_err. Else if (^data ^ parity) != 1, pulse parity_err. Else the byte is accepted.
- Timeout: a counter runs in every state other than IDLE and clears on each fall. When it reaches TIMEOUT_CYCLES, return to IDLE, pulse frame_err, and clear brk_pend and ext_pend.
- Accepted byte handling (rx_byte is always updated):
  - F0: set brk_pend. No other output changes.
  - E0: set ext_pend. No other output changes.
  - Other byte with brk_pend set: pulse key_release. If keycode equals the byte, set keycode to 00 and extended to 0. Clear both pending flags.
  - Other byte with brk_pend clear: pulse key_valid, load keycode with the byte, load extended from ext_pend, clear ext_pend.
- Errors: any parity or frame error clears brk_pend and ext_pend. keycode and rx_byte are unchanged.
- Latency: all outputs update at the clk edge that ends the fall cycle of the stop bit.
  - Pulses last exactly 1 cycle.
  - At most one of key_valid, key_release, parity_err, frame_err is asserted in any cycle.
- Reset mid-frame discards the partial frame with no error pulse.
- Repeated make codes (typematic): each one pulses key_valid again with the same keycode.

Optional Feature:
PS2_ERR_COUNT_EN
- Defined: adds output err_count (8 bits). It increments on every parity_err or frame_err pulse, saturates at 255, and resets to 0.
- Undefined: the port and counter are absent, and nothing else changes.

Test Plan:
- Frame 1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), bit period 40 us -> key_valid pulse once; keycode = 1C; extended = 0; rx_byte = 1C.
- Sequence 1C, then F0 1C -> after F0 no strobe and rx_byte = F0; after the second 1C, key_release pulses and keycode = 00.
- Sequence E0 75 -> key_valid pulses; keycode = 75; extended = 1. Then E0 F0 75 -> key_release pulses; keycode = 00; extended = 0.
- Frame 15 with its parity bit inverted -> parity_err pulses once; keycode keeps its prior value. The following valid 1D is accepted normally.
- Glitch pulses on PS2Clk shorter than FILTER_LEN cycles mid-frame -> no extra bits are shifted and the frame decodes correctly. Halting PS2Clk after 4 data bits -> frame_err exactly TIMEOUT_CYCLES cycles after the last fall; the next full frame 24 is decoded.
- rst_n low for 1 cycle after bit 5 of a frame -> all outputs 0 with no pulse. The next frame 76 gives keycode = 76. With PS2_ERR_COUNT_EN, 300 bad-stop frames -> err_count = 255.
